// File: rtl/hpm_threshold_sampler.sv
// Flags HPM counters crossing their thresholds (sticky status + irq) and writes one counter snapshot per crossing.
// Status/irq one cycle after the crossing, write request one cycle later; a request holds until mem_gnt_i.
module hpm_threshold_sampler #(
    parameter int unsigned NumCounters = 6,
    parameter int unsigned AddrWidth   = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumCounters-1:0][63:0]     counter_i,
    input  logic [NumCounters-1:0][63:0]     threshold_i,
    input  logic [NumCounters-1:0]           inhibit_i,
    input  logic [NumCounters-1:0]           irq_en_i,
    input  logic [AddrWidth-1:0]             mmaped_base_i,
    input  logic                             clr_valid_i,
    input  logic [NumCounters-1:0]           clr_mask_i,
    output logic [NumCounters-1:0]           ovf_status_o,
    output logic                             irq_o,
    output logic                             mem_req_o,
    input  logic                             mem_gnt_i,
    output logic [AddrWidth-1:0]             mem_addr_o,
    output logic [63:0]                      mem_wdata_o,
    output logic                             busy_o
);

    localparam int unsigned IdxW = (NumCounters > 1) ? $clog2(NumCounters) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [NumCounters-1:0]  w_ge;
    logic [NumCounters-1:0]  w_cross;
    logic [NumCounters-1:0]  w_ovf_clr;
    logic [NumCounters-1:0]  w_pend_clr;
    logic [NumCounters-1:0]  r_ge_q;
    logic [NumCounters-1:0]  r_ovf_q;
    logic [NumCounters-1:0]  r_pend_q;
    logic [IdxW-1:0]         w_sel_idx;
    logic                    w_issue;
    logic                    w_discard;
    logic [AddrWidth-1:0]    w_addr_nxt;
    logic [AddrWidth-1:0]    r_addr_q;
    logic [63:0]             r_snap_q;

    always_comb begin
        w_ge = '0;
        for (int i = 0; i < NumCounters; i++) begin
            w_ge[i] = !inhibit_i[i] && (threshold_i[i] != 64'd0) && (counter_i[i] >= threshold_i[i]);
        end
    end

    // Rising edge only: a counter parked above its threshold raises a single event.
    assign w_cross   = w_ge & ~r_ge_q;
    assign w_ovf_clr = clr_valid_i ? clr_mask_i : '0;

    always_comb begin
        w_sel_idx = '0;
        for (int i = NumCounters - 1; i >= 0; i--) begin
            if (r_pend_q[i]) w_sel_idx = IdxW'(i);
        end
    end

    assign w_addr_nxt = mmaped_base_i + ({{(AddrWidth-IdxW){1'b0}}, w_sel_idx} << 3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_discard   = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        busy_o      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend_q != '0) begin
                    if (mmaped_base_i != '0) begin
                        w_issue     = 1'b1;
                        w_state_nxt = WRITE;
                    end else begin
                        w_discard   = 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = r_addr_q;
                mem_wdata_o = r_snap_q;
                busy_o      = 1'b1;
                if (mem_gnt_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pend_clr = '0;
        if (w_discard)    w_pend_clr            = '1;
        else if (w_issue) w_pend_clr[w_sel_idx] = 1'b1;
    end

    // New crossings are OR-ed in after the clears so a same-cycle set always wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ge_q   <= '0;
            r_ovf_q  <= '0;
            r_pend_q <= '0;
            r_snap_q <= '0;
            r_addr_q <= '0;
        end else begin
            r_ge_q   <= w_ge;
            r_ovf_q  <= (r_ovf_q & ~w_ovf_clr) | w_cross;
            r_pend_q <= (r_pend_q & ~w_pend_clr) | w_cross;
            if (w_issue) begin
                r_snap_q <= counter_i[w_sel_idx];
                r_addr_q <= w_addr_nxt;
            end
        end
    end

    assign ovf_status_o = r_ovf_q;
    assign irq_o        = |(r_ovf_q & irq_en_i);

endmodule
